// File: rtl/disp_pkg.sv
// Shared constants, state encoding and the page-selection helper for the display scheduler.
package disp_pkg;

  localparam int SRC_COUNT = 4;
  localparam int PAGE_W    = 2;
  localparam int DATA_W    = 16;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } disp_state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round-robin search from page+1; the current page is tried last, and is kept if nothing is valid.
  function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0]    page,
                                                  input logic [SRC_COUNT-1:0] valid);
    logic [PAGE_W-1:0] idx;
    next_page = page;
    for (int i = SRC_COUNT; i >= 1; i--) begin
      idx = page + PAGE_W'(i);
      if (valid[idx]) next_page = idx;
    end
  endfunction

endpackage

// File: rtl/disp_if.sv
// Bundle between the datapath sources and the display scheduler.
interface disp_if;
  import disp_pkg::*;

  // src_valid[i] qualifies srcI_data; outputs are registered and disp_data is meaningful only while disp_blank=0.
  logic [DATA_W-1:0]    src0_data;
  logic [DATA_W-1:0]    src1_data;
  logic [DATA_W-1:0]    src2_data;
  logic [DATA_W-1:0]    src3_data;
  logic [SRC_COUNT-1:0] src_valid;
  logic                 auto_en;
  logic                 freeze;
  logic                 scan_tick;
  logic [DATA_W-1:0]    disp_data;
  logic                 disp_blank;
  logic [PAGE_W-1:0]    page;
  disp_state_t          state;

  modport master (
    output src0_data, src1_data, src2_data, src3_data, src_valid, auto_en, freeze,
    input  scan_tick, disp_data, disp_blank, page, state
  );

  modport slave (
    input  src0_data, src1_data, src2_data, src3_data, src_valid, auto_en, freeze,
    output scan_tick, disp_data, disp_blank, page, state
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and rising-edge pulse.
module btn_debounce
  import disp_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic CLK,
  input  logic clr_n,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int            CW       = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  // The pulse is registered alongside the stable update so it is exactly one cycle wide.
  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      btn_pulse <= 1'b0;
    end else begin
      sync_q1   <= btn_raw;
      sync_q2   <= sync_q1;
      btn_pulse <= 1'b0;
      if (sync_q2 == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q     <= '0;
        stable_q  <= sync_q2;
        btn_pulse <= sync_q2;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 4-digit display between four sources: scan prescaler, page FSM with
// blanking between pages, button and auto-rotate page advance.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 500000,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int AUTO_DWELL   = 200,
  parameter int BLANK_TICKS  = 2
) (
  input  logic CLK,
  input  logic clr_n,
  input  logic btn_next,
  disp_if.slave bus
);

  localparam int            SW         = cnt_w(SCAN_DIV);
  localparam int            DW         = cnt_w(AUTO_DWELL);
  localparam int            BW         = cnt_w(BLANK_TICKS);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(AUTO_DWELL - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_TICKS - 1);

  logic [SW-1:0]     scan_cnt_q;
  logic              scan_tick;
  logic              btn_pulse;
  logic              advance;
  logic [DATA_W-1:0] src_sel;

  disp_state_t       state_q;
  logic [PAGE_W-1:0] page_q;
  logic [DATA_W-1:0] data_q;
  logic              blank_q;
  logic [BW-1:0]     blank_cnt_q;
  logic [DW-1:0]     dwell_q;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .CLK       (CLK),
    .clr_n     (clr_n),
    .btn_raw   (btn_next),
    .btn_pulse (btn_pulse)
  );

  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n)         scan_cnt_q <= '0;
    else if (scan_tick) scan_cnt_q <= '0;
    else                scan_cnt_q <= scan_cnt_q + SW'(1);
  end

  assign scan_tick = (scan_cnt_q == SCAN_LAST);

  always_comb begin
    src_sel = bus.src0_data;
    case (page_q)
      2'd1:    src_sel = bus.src1_data;
      2'd2:    src_sel = bus.src2_data;
      2'd3:    src_sel = bus.src3_data;
      default: src_sel = bus.src0_data;
    endcase
  end

  // Button, dwell expiry and loss of the current source all collapse into one advance.
  assign advance = btn_pulse
                 | (bus.auto_en & ~bus.freeze & scan_tick & (dwell_q == DWELL_LAST))
                 | ~bus.src_valid[page_q];

  always_ff @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= BLANK;
      page_q      <= '0;
      data_q      <= '0;
      blank_q     <= 1'b1;
      blank_cnt_q <= '0;
      dwell_q     <= '0;
    end else begin
      case (state_q)
        BLANK: begin
          blank_q <= 1'b1;
          if (scan_tick) begin
            if (blank_cnt_q == BLANK_LAST) begin
              blank_cnt_q <= '0;
              if (bus.src_valid[page_q]) begin
                data_q  <= src_sel;
                blank_q <= 1'b0;
                dwell_q <= '0;
                state_q <= SHOW;
              end
            end else begin
              blank_cnt_q <= blank_cnt_q + BW'(1);
            end
          end
        end
        SHOW: begin
          if (scan_tick && !bus.freeze) data_q <= src_sel;
          if (!bus.auto_en)                  dwell_q <= '0;
          else if (scan_tick && !bus.freeze) dwell_q <= dwell_q + DW'(1);
          if (advance) begin
            page_q      <= next_page(page_q, bus.src_valid);
            blank_cnt_q <= '0;
            blank_q     <= 1'b1;
            state_q     <= BLANK;
          end
        end
      endcase
    end
  end

  assign bus.scan_tick  = scan_tick;
  assign bus.disp_data  = data_q;
  assign bus.disp_blank = blank_q;
  assign bus.page       = page_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: scenario tasks compare the DUT against a
// behavioural model of the page/blank/dwell rules and the button acceptance window.
module tb_display_scheduler;
  import disp_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CYC = 3;
  localparam int AUTO_DWELL   = 5;
  localparam int BLANK_TICKS  = 2;

  logic CLK      = 1'b0;
  logic clr_n    = 1'b0;
  logic btn_next = 1'b0;

  disp_if bus ();

  display_scheduler #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .AUTO_DWELL   (AUTO_DWELL),
    .BLANK_TICKS  (BLANK_TICKS)
  ) dut (
    .CLK      (CLK),
    .clr_n    (clr_n),
    .btn_next (btn_next),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  // ---------------- reference model ----------------
  int         m_edges;
  logic [1:0] m_page;
  logic [15:0] m_data;
  logic       m_blank;
  int         m_blank_seen;
  int         m_shown;
  logic       m_d1, m_d2, m_stable, m_pulse, m_tick, m_adv;
  int         m_ndiff;
  logic       sync_hist[$];

  function automatic logic [15:0] src_word(input logic [1:0] p);
    case (p)
      2'd0:    return bus.src0_data;
      2'd1:    return bus.src1_data;
      2'd2:    return bus.src2_data;
      default: return bus.src3_data;
    endcase
  endfunction

  function automatic logic [1:0] model_next(input logic [1:0] p, input logic [3:0] v);
    logic found;
    found = 1'b0;
    model_next = p;
    for (int k = 1; k <= 4; k++) begin
      if (!found && v[(int'(p) + k) % 4]) begin
        model_next = 2'((int'(p) + k) % 4);
        found = 1'b1;
      end
    end
  endfunction

  always @(posedge CLK or negedge clr_n) begin
    if (!clr_n) begin
      m_edges = 0; m_page = 2'd0; m_data = 16'h0; m_blank = 1'b1;
      m_blank_seen = 0; m_shown = 0;
      m_d1 = 1'b0; m_d2 = 1'b0; m_stable = 1'b0; m_pulse = 1'b0;
      sync_hist.delete();
    end else begin
      m_tick = (m_edges % SCAN_DIV) == SCAN_DIV - 1;
      if (m_blank) begin
        if (m_tick) begin
          m_blank_seen++;
          if (m_blank_seen == BLANK_TICKS) begin
            m_blank_seen = 0;
            if (bus.src_valid[m_page]) begin
              m_blank = 1'b0;
              m_data  = src_word(m_page);
              m_shown = 0;
            end
          end
        end
      end else begin
        m_adv = m_pulse || (bus.auto_en && !bus.freeze && m_tick && m_shown == AUTO_DWELL - 1)
                || !bus.src_valid[m_page];
        if (m_tick && !bus.freeze) begin
          m_data = src_word(m_page);
          if (bus.auto_en) m_shown++;
        end
        if (!bus.auto_en) m_shown = 0;
        if (m_adv) begin
          m_page = model_next(m_page, bus.src_valid);
          m_blank = 1'b1;
          m_blank_seen = 0;
        end
      end
      // Accept the button once the synchronised level has disagreed with the stable level for a full window.
      sync_hist.push_back(m_d2);
      if (sync_hist.size() > DEBOUNCE_CYC) void'(sync_hist.pop_front());
      m_ndiff = 0;
      foreach (sync_hist[k]) if (sync_hist[k] != m_stable) m_ndiff++;
      m_pulse = 1'b0;
      if (m_ndiff == DEBOUNCE_CYC) begin
        m_stable = ~m_stable;
        m_pulse  = m_stable;
      end
      m_d2 = m_d1;
      m_d1 = btn_next;
      m_edges++;
    end
  end

  function automatic logic [19:0] exp_vec();
    return {((m_edges % SCAN_DIV) == SCAN_DIV - 1), m_data, m_blank, m_page};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {bus.scan_tick, bus.disp_data, bus.disp_blank, bus.page};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_button(input int hold);
    btn_next = 1'b1;
    repeat (hold) @(negedge CLK);
    btn_next = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clr_n = 1'b0; btn_next = 1'b0;
    bus.src0_data = 16'h1234; bus.src1_data = 16'($urandom);
    bus.src2_data = 16'($urandom); bus.src3_data = 16'($urandom);
    bus.src_valid = 4'hF; bus.auto_en = 1'b0; bus.freeze = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.disp_data !== 16'h0 || bus.disp_blank !== 1'b1 || bus.page !== 2'd0 ||
        bus.scan_tick !== 1'b0 || bus.state !== BLANK) begin
      errors++;
      $display("FAIL reset data=%h blank=%b page=%0d tick=%b state=%0d (want 0000 1 0 0 0)",
               bus.disp_data, bus.disp_blank, bus.page, bus.scan_tick, bus.state);
    end
  endtask

  task automatic test_power_on();
    clr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL power_on cyc=%0d obs=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.disp_data !== 16'h1234 || bus.disp_blank !== 1'b0 || bus.page !== 2'd0) begin
      errors++;
      $display("FAIL power_on_show data=%h blank=%b page=%0d (want 1234 0 0)",
               bus.disp_data, bus.disp_blank, bus.page);
    end
  endtask

  task automatic test_button();
    btn_next = 1'b1;
    for (int i = 0; i < 46; i++) begin
      @(negedge CLK);
      if (i == 5) btn_next = 1'b0;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL button cyc=%0d obs=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.page !== 2'd1 || bus.disp_blank !== 1'b0 || bus.disp_data !== bus.src1_data) begin
      errors++;
      $display("FAIL button_page page=%0d blank=%b data=%h (want 1 0 %h)",
               bus.page, bus.disp_blank, bus.disp_data, bus.src1_data);
    end
    btn_next = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i == 1) btn_next = 1'b0;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL glitch cyc=%0d obs=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.page !== 2'd1 || bus.disp_blank !== 1'b0) begin
      errors++;
      $display("FAIL glitch_page page=%0d blank=%b (want 1 0)", bus.page, bus.disp_blank);
    end
  endtask

  task automatic test_auto();
    int show_len, blank_len, shows_seen;
    logic prev_blank;
    logic [1:0] want;
    show_len = 0; blank_len = 0; shows_seen = 0;
    exp_q.delete();
    exp_q.push_back(2'd2);
    bus.src_valid = 4'b0101;
    bus.auto_en   = 1'b1;
    prev_blank    = bus.disp_blank;
    for (int i = 0; i < 160; i++) begin
      @(negedge CLK);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL auto cyc=%0d obs=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (prev_blank && !bus.disp_blank) begin
        shows_seen++;
        if (shows_seen >= 2) begin
          checks++;
          if (blank_len != BLANK_TICKS * SCAN_DIV) begin
            errors++;
            $display("FAIL auto_blank_len got=%0d want=%0d", blank_len, BLANK_TICKS * SCAN_DIV);
          end
        end
        want = exp_q.pop_front();
        checks++;
        if (bus.page !== want) begin
          errors++;
          $display("FAIL auto_page_seq got=%0d want=%0d", bus.page, want);
        end
        exp_q.push_back(want ^ 2'd2);
        show_len = 0;
      end else if (!prev_blank && bus.disp_blank && shows_seen >= 1) begin
        checks++;
        if (show_len != AUTO_DWELL * SCAN_DIV) begin
          errors++;
          $display("FAIL auto_show_len got=%0d want=%0d", show_len, AUTO_DWELL * SCAN_DIV);
        end
        blank_len = 0;
      end
      if (bus.disp_blank) blank_len++;
      else                show_len++;
      prev_blank = bus.disp_blank;
    end
    checks++;
    if (shows_seen < 4) begin
      errors++;
      $display("FAIL auto_rotations got=%0d want>=4", shows_seen);
    end
  endtask

  task automatic test_drop();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge CLK);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drop_wait cyc=%0d obs=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (!bus.disp_blank && bus.page == 2'd2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drop_reach_page2 timeout page=%0d blank=%b", bus.page, bus.disp_blank);
    end
    bus.auto_en   = 1'b0;
    bus.src_valid = 4'b0001;
    @(negedge CLK);
    checks++;
    if (bus.disp_blank !== 1'b1 || bus.page !== 2'd0) begin
      errors++;
      $display("FAIL drop_blank blank=%b page=%0d (want 1 0)", bus.disp_blank, bus.page);
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL drop_show cyc=%0d obs=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (!bus.disp_blank) found = 1'b1;
    end
    bus.src_valid = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.disp_blank !== 1'b1 || bus.page !== 2'd0 || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL none_valid cyc=%0d blank=%b page=%0d obs=%h exp=%h",
                 i, bus.disp_blank, bus.page, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_freeze();
    logic [15:0] old_word;
    logic found;
    bus.src_valid = 4'hF;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      if (!bus.disp_blank) found = 1'b1;
    end
    checks++;
    if (!found || bus.page !== 2'd0) begin
      errors++;
      $display("FAIL freeze_setup found=%b page=%0d (want 1 0)", found, bus.page);
    end
    old_word      = bus.src0_data;
    bus.freeze    = 1'b1;
    bus.auto_en   = 1'b1;
    bus.src0_data = 16'hBEEF;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.disp_data !== old_word || bus.page !== 2'd0 || bus.disp_blank !== 1'b0 ||
          dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL freeze_hold cyc=%0d data=%h page=%0d want=%h 0, model=%h",
                 i, bus.disp_data, bus.page, old_word, exp_vec());
      end
    end
    for (int p = 1; p <= 4; p++) begin
      drive_button(6);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
        @(negedge CLK);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL freeze_press cyc=%0d obs=%h exp=%h", i, dut_vec(), exp_vec());
        end
        if (!bus.disp_blank) found = 1'b1;
      end
      checks++;
      if (!found || bus.page !== 2'(p % 4)) begin
        errors++;
        $display("FAIL freeze_advance found=%b page=%0d want=%0d", found, bus.page, p % 4);
      end
      repeat (4) @(negedge CLK);
    end
    checks++;
    if (bus.disp_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL freeze_reload data=%h want=beef", bus.disp_data);
    end
  endtask

  task automatic test_async_reset();
    bus.freeze  = 1'b0;
    bus.auto_en = 1'b0;
    drive_button(6);
    bus.src_valid = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d obs=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.page !== 2'd1 || bus.disp_blank !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state page=%0d blank=%b (want 1 1)", bus.page, bus.disp_blank);
    end
    btn_next = 1'b1;
    repeat (3) @(negedge CLK);
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if (bus.disp_data !== 16'h0 || bus.disp_blank !== 1'b1 || bus.page !== 2'd0 ||
        bus.scan_tick !== 1'b0 || bus.state !== BLANK) begin
      errors++;
      $display("FAIL async_reset data=%h blank=%b page=%0d tick=%b (want 0000 1 0 0)",
               bus.disp_data, bus.disp_blank, bus.page, bus.scan_tick);
    end
    btn_next = 1'b0;
    bus.src_valid = 4'hF;
    repeat (2) @(negedge CLK);
    clr_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset cyc=%0d obs=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.page !== 2'd0 || bus.disp_blank !== 1'b0 || bus.disp_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL post_reset_show page=%0d blank=%b data=%h (want 0 0 beef)",
               bus.page, bus.disp_blank, bus.disp_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d obs=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if ($urandom_range(0, 39) == 0) bus.src_valid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) bus.auto_en = ~bus.auto_en;
      if ($urandom_range(0, 49) == 0) bus.freeze = ~bus.freeze;
      if ($urandom_range(0, 14) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.src0_data = 16'($urandom);
          1:       bus.src1_data = 16'($urandom);
          2:       bus.src2_data = 16'($urandom);
          default: bus.src3_data = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 699) == 0) begin
        #2 clr_n = 1'b0;
        #1 clr_n = 1'b1;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_power_on();
    test_button();
    test_auto();
    test_drop();
    test_freeze();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
